// File: rtl/lpc_io_target.sv
// lpc_io_target: LPC I/O-cycle target with a relocatable register window,
// programmable SYNC long-wait and a POST-code FIFO with overflow tracking.
`default_nettype none

module lpc_io_target #(
    parameter logic [15:0] BASE_ADDR  = 16'h0800,
    parameter int          ADDR_BITS  = 5,
    parameter logic [15:0] POST_PORT  = 16'h0080,
    parameter int          POST_DEPTH = 8,
    parameter int          SYNC_WAIT  = 0
) (
    input  logic                          LpcClock,
    input  logic                          PciReset,
    input  logic                          LpcFrame,
    input  logic [3:0]                    LpcBusIn,
    output logic [3:0]                    LpcBusOut,
    output logic                          LpcBusOe,
    output logic                          RegWr,
    output logic                          RegRd,
    output logic [ADDR_BITS-1:0]          RegAddr,
    output logic [7:0]                    RegWrData,
    input  logic [7:0]                    RegRdData,
    output logic [7:0]                    PostData,
    output logic                          PostValid,
    input  logic                          PostPop,
    output logic [$clog2(POST_DEPTH):0]   PostCount,
    output logic [7:0]                    PostLast,
    output logic                          PostOvf,
    input  logic                          PostOvfClr,
    output logic                          CycleAbort
);

    localparam int                PTR_W   = $clog2(POST_DEPTH);
    localparam logic [3:0]        WAIT_N  = 4'(SYNC_WAIT);
    localparam logic [PTR_W:0]    DEPTH_N = (PTR_W + 1)'(POST_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_CYCTYPE, S_ADDR, S_WDATA, S_HTAR, S_SYNC, S_RDATA, S_PTAR
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic        r_hit;
    logic        r_post;
    logic        r_ready;
    logic [11:0] r_addr;
    logic [7:0]  r_wdata;
    logic [3:0]  r_rd_hi;
    logic [3:0]  r_bus_out;
    logic        r_bus_oe;
    logic        r_reg_wr;
    logic        r_reg_rd;
    logic        r_abort;

    logic [15:0] w_addr_full;
    logic        w_win_hit;
    logic        w_post_hit;

    assign w_addr_full = {r_addr, LpcBusIn};
    assign w_win_hit   = (w_addr_full[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
    assign w_post_hit  = r_write && (w_addr_full == POST_PORT);

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_write   <= 1'b0;
            r_hit     <= 1'b0;
            r_post    <= 1'b0;
            r_ready   <= 1'b0;
            r_addr    <= 12'd0;
            r_wdata   <= 8'd0;
            r_rd_hi   <= 4'd0;
            r_bus_out <= 4'd0;
            r_bus_oe  <= 1'b0;
            r_reg_wr  <= 1'b0;
            r_reg_rd  <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_reg_wr <= 1'b0;
            r_reg_rd <= 1'b0;
            r_abort  <= 1'b0;
            if (!LpcFrame) begin
                // Frame low always restarts START detection, aborting any cycle in flight.
                r_abort   <= (r_state != S_IDLE) && r_hit;
                r_hit     <= 1'b0;
                r_post    <= 1'b0;
                r_ready   <= 1'b0;
                r_bus_oe  <= 1'b0;
                r_bus_out <= 4'd0;
                r_cnt     <= 4'd0;
                r_state   <= (LpcBusIn == 4'h0) ? S_CYCTYPE : S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_IDLE;
                    S_CYCTYPE: begin
                        r_write <= LpcBusIn[1];
                        r_cnt   <= 4'd0;
                        r_state <= (LpcBusIn[3:2] == 2'b00) ? S_ADDR : S_IDLE;
                    end
                    S_ADDR: begin
                        r_addr <= w_addr_full[11:0];
                        if (r_cnt == 4'd3) begin
                            r_cnt <= 4'd0;
                            if (w_win_hit || w_post_hit) begin
                                r_hit   <= 1'b1;
                                r_post  <= w_post_hit && !w_win_hit;
                                r_state <= r_write ? S_WDATA : S_HTAR;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    S_WDATA: begin
                        if (r_cnt == 4'd0) begin
                            r_wdata[3:0] <= LpcBusIn;
                            r_cnt        <= 4'd1;
                        end else begin
                            r_wdata[7:4] <= LpcBusIn;
                            r_cnt        <= 4'd0;
                            r_state      <= S_HTAR;
                        end
                    end
                    S_HTAR: begin
                        if (r_cnt == 4'd0) begin
                            r_reg_rd <= !r_write;
                            r_cnt    <= 4'd1;
                        end else begin
                            r_state  <= S_SYNC;
                            r_bus_oe <= 1'b1;
                            r_cnt    <= 4'd0;
                            if (WAIT_N == 4'd0) begin
                                r_ready   <= 1'b1;
                                r_bus_out <= 4'b0000;
                                r_reg_wr  <= r_write && !r_post;
                            end else begin
                                r_ready   <= 1'b0;
                                r_bus_out <= 4'b0110;
                            end
                        end
                    end
                    S_SYNC: begin
                        if (!r_ready) begin
                            if (r_cnt == WAIT_N - 4'd1) begin
                                r_ready   <= 1'b1;
                                r_bus_out <= 4'b0000;
                                r_reg_wr  <= r_write && !r_post;
                            end else begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end else begin
                            r_cnt <= 4'd0;
                            if (r_write) begin
                                r_bus_out <= 4'hF;
                                r_state   <= S_PTAR;
                            end else begin
                                r_bus_out <= RegRdData[3:0];
                                r_rd_hi   <= RegRdData[7:4];
                                r_state   <= S_RDATA;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (r_cnt == 4'd0) begin
                            r_bus_out <= r_rd_hi;
                            r_cnt     <= 4'd1;
                        end else begin
                            r_bus_out <= 4'hF;
                            r_cnt     <= 4'd0;
                            r_state   <= S_PTAR;
                        end
                    end
                    S_PTAR: begin
                        if (r_cnt == 4'd0) begin
                            r_bus_oe  <= 1'b0;
                            r_bus_out <= 4'd0;
                            r_cnt     <= 4'd1;
                        end else begin
                            r_cnt   <= 4'd0;
                            r_hit   <= 1'b0;
                            r_post  <= 1'b0;
                            r_ready <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign LpcBusOut  = r_bus_out;
    assign LpcBusOe   = r_bus_oe;
    assign RegWr      = r_reg_wr;
    assign RegRd      = r_reg_rd;
    assign RegAddr    = r_addr[ADDR_BITS-1:0];
    assign RegWrData  = r_wdata;
    assign CycleAbort = r_abort;

    logic [7:0]       r_mem [POST_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [7:0]       r_last;
    logic             r_ovf;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_wr_en;

    assign w_push  = (r_state == S_SYNC) && r_ready && r_post;
    assign w_full  = (r_count == DEPTH_N);
    assign w_pop   = PostPop && (r_count != '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= 8'd0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (PTR_W + 1)'(w_wr_en) - (PTR_W + 1)'(w_pop);
            if (w_push) r_last <= r_wdata;
            if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
            else if (PostOvfClr)            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge LpcClock) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= r_wdata;
    end

    assign PostValid = (r_count != '0);
    assign PostData  = PostValid ? r_mem[r_rd_ptr] : 8'h00;
    assign PostCount = r_count;
    assign PostLast  = r_last;
    assign PostOvf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_lpc_io_target.sv
// tb_lpc_io_target: directed bench; two instances differ only in SYNC_WAIT (0 and 2).
`default_nettype none

module tb_lpc_io_target;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame;
    logic [3:0] bus_in;
    logic [7:0] rd_data;
    logic       post_pop;
    logic       ovf_clr;

    logic [3:0] out0, out2;
    logic       oe0, oe2, wr0, wr2, rd0, rd2, pvalid0, pvalid2, povf0, povf2, abort0, abort2;
    logic [4:0] addr0, addr2;
    logic [7:0] wdata0, wdata2, pdata0, pdata2, plast0, plast2;
    logic [3:0] pcount0, pcount2;

    int passed = 0;
    int failed = 0;
    int n_wr0 = 0, n_rd0 = 0, n_wr2 = 0, n_rd2 = 0, n_oe0 = 0, n_oe2 = 0, n_ab0 = 0, n_ab2 = 0;
    int b0, b1, b2, b3;

    always #15 clk = ~clk;

    lpc_io_target #(.SYNC_WAIT(0)) u_dut0 (
        .LpcClock(clk), .PciReset(rst_n), .LpcFrame(frame), .LpcBusIn(bus_in),
        .LpcBusOut(out0), .LpcBusOe(oe0), .RegWr(wr0), .RegRd(rd0), .RegAddr(addr0),
        .RegWrData(wdata0), .RegRdData(rd_data), .PostData(pdata0), .PostValid(pvalid0),
        .PostPop(post_pop), .PostCount(pcount0), .PostLast(plast0), .PostOvf(povf0),
        .PostOvfClr(ovf_clr), .CycleAbort(abort0)
    );

    lpc_io_target #(.SYNC_WAIT(2)) u_dut2 (
        .LpcClock(clk), .PciReset(rst_n), .LpcFrame(frame), .LpcBusIn(bus_in),
        .LpcBusOut(out2), .LpcBusOe(oe2), .RegWr(wr2), .RegRd(rd2), .RegAddr(addr2),
        .RegWrData(wdata2), .RegRdData(rd_data), .PostData(pdata2), .PostValid(pvalid2),
        .PostPop(post_pop), .PostCount(pcount2), .PostLast(plast2), .PostOvf(povf2),
        .PostOvfClr(ovf_clr), .CycleAbort(abort2)
    );

    always @(posedge clk) begin
        if (wr0)    n_wr0++;
        if (rd0)    n_rd0++;
        if (wr2)    n_wr2++;
        if (rd2)    n_rd2++;
        if (oe0)    n_oe0++;
        if (oe2)    n_oe2++;
        if (abort0) n_ab0++;
        if (abort2) n_ab2++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic f, input logic [3:0] n);
        frame  = f;
        bus_in = n;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 4'hF);
    endtask

    task automatic write_hdr(input logic [15:0] a, input logic [7:0] d);
        step(1'b0, 4'h0);
        step(1'b1, 4'h2);
        step(1'b1, a[15:12]);
        step(1'b1, a[11:8]);
        step(1'b1, a[7:4]);
        step(1'b1, a[3:0]);
        step(1'b1, d[3:0]);
        step(1'b1, d[7:4]);
    endtask

    task automatic read_hdr(input logic [15:0] a);
        step(1'b0, 4'h0);
        step(1'b1, 4'h0);
        step(1'b1, a[15:12]);
        step(1'b1, a[11:8]);
        step(1'b1, a[7:4]);
        step(1'b1, a[3:0]);
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        write_hdr(a, d);
        idle(8);
    endtask

    initial begin
        logic [3:0] rseq [6];
        rseq = '{4'h6, 4'h6, 4'h0, 4'hC, 4'h5, 4'hF};
        rst_n = 1'b0; frame = 1'b1; bus_in = 4'hF; rd_data = 8'h00; post_pop = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        idle(2);
        check("rst_oe", oe0, 0);
        check("rst_out", out0, 0);
        check("rst_pcount", pcount0, 0);
        check("rst_pvalid", pvalid0, 0);
        check("rst_povf", povf0, 0);
        check("rst_wr", wr0, 0);
        check("rst_abort", abort0, 0);
        rst_n = 1'b1;
        idle(2);

        // I/O write 0x0803 <- 0xA5, no wait states
        b0 = n_wr0; b1 = n_rd0;
        write_hdr(16'h0803, 8'hA5);
        step(1'b1, 4'hF);
        check("wr_htar_oe", oe0, 0);
        step(1'b1, 4'hF);
        check("wr_sync_oe", oe0, 1);
        check("wr_sync_val", out0, 4'h0);
        check("wr_strobe", wr0, 1);
        check("wr_addr", addr0, 5'd3);
        check("wr_data", wdata0, 8'hA5);
        step(1'b1, 4'hF);
        check("wr_ptar_oe", oe0, 1);
        check("wr_ptar_val", out0, 4'hF);
        check("wr_strobe_end", wr0, 0);
        step(1'b1, 4'hF);
        check("wr_release", oe0, 0);
        idle(6);
        check("wr_count", n_wr0 - b0, 1);
        check("wr_no_rd", n_rd0 - b1, 0);

        // I/O read 0x081F, two wait states
        rd_data = 8'h5C;
        b0 = n_rd2;
        read_hdr(16'h081F);
        step(1'b1, 4'hF);
        check("rd_strobe", rd2, 1);
        check("rd_addr", addr2, 5'h1F);
        step(1'b1, 4'hF);
        for (int i = 0; i < 6; i++) begin
            check("rd_seq_oe", oe2, 1);
            check("rd_seq_val", out2, rseq[i]);
            step(1'b1, 4'hF);
        end
        check("rd_release", oe2, 0);
        idle(4);
        check("rd_count", n_rd2 - b0, 1);

        // Misses: window miss, POST read, memory cycle
        b0 = n_oe0; b1 = n_oe2; b2 = n_wr0 + n_wr2; b3 = n_rd0 + n_rd2;
        write_hdr(16'h0900, 8'h11);
        idle(10);
        read_hdr(16'h0080);
        idle(10);
        step(1'b0, 4'h0);
        step(1'b1, 4'h4);
        for (int i = 0; i < 4; i++) step(1'b1, 4'h0);
        idle(10);
        check("miss_oe0", n_oe0 - b0, 0);
        check("miss_oe2", n_oe2 - b1, 0);
        check("miss_wr", n_wr0 + n_wr2 - b2, 0);
        check("miss_rd", n_rd0 + n_rd2 - b3, 0);
        check("miss_fifo", pcount0, 0);

        // Nine POST writes into an 8-deep FIFO
        b0 = n_wr0;
        for (int i = 1; i <= 9; i++) io_write(16'h0080, 8'(i));
        check("post_count", pcount0, 8);
        check("post_ovf", povf0, 1);
        check("post_last", plast0, 8'h09);
        check("post_head", pdata0, 8'h01);
        check("post_no_regwr", n_wr0 - b0, 0);
        for (int i = 1; i <= 8; i++) begin
            check("post_pop_data", pdata0, 8'(i));
            post_pop = 1'b1;
            step(1'b1, 4'hF);
            post_pop = 1'b0;
        end
        check("post_empty", pvalid0, 0);
        check("post_empty_cnt", pcount0, 0);
        ovf_clr = 1'b1;
        step(1'b1, 4'hF);
        ovf_clr = 1'b0;
        check("post_ovf_clr", povf0, 0);

        // Abort during address nibble 3; the abort cycle doubles as the next START
        b0 = n_ab0; b1 = n_wr0;
        step(1'b0, 4'h0);
        step(1'b1, 4'h2);
        step(1'b1, 4'h0);
        step(1'b1, 4'h8);
        step(1'b0, 4'h0);
        check("ab1_no_abort", abort0, 0);
        step(1'b1, 4'h2);
        step(1'b1, 4'h0);
        step(1'b1, 4'h8);
        step(1'b1, 4'h0);
        step(1'b1, 4'h0);
        step(1'b1, 4'hC);
        step(1'b1, 4'h3);
        idle(8);
        check("ab1_abort_cnt", n_ab0 - b0, 0);
        check("ab1_wr_cnt", n_wr0 - b1, 1);
        check("ab1_wdata", wdata0, 8'h3C);
        check("ab1_addr", addr0, 5'd0);

        // Abort during SYNC wait of a hit read
        b0 = n_oe2; b1 = n_ab2;
        read_hdr(16'h0804);
        step(1'b1, 4'hF);
        step(1'b1, 4'hF);
        check("ab2_oe", oe2, 1);
        check("ab2_wait", out2, 4'h6);
        step(1'b0, 4'hF);
        check("ab2_release", oe2, 0);
        check("ab2_pulse", abort2, 1);
        step(1'b1, 4'hF);
        check("ab2_pulse_end", abort2, 0);
        idle(6);
        check("ab2_oe_cycles", n_oe2 - b0, 1);
        check("ab2_abort_cnt", n_ab2 - b1, 1);

        // Reset during RDATA
        io_write(16'h0080, 8'h77);
        check("rs_pcount", pcount0, 1);
        check("rs_plast", plast0, 8'h77);
        read_hdr(16'h0802);
        for (int i = 0; i < 5; i++) step(1'b1, 4'hF);
        check("rs_rdata_oe", oe2, 1);
        check("rs_rdata_val", out2, 4'hC);
        rst_n = 1'b0;
        #1;
        check("rs_oe", oe2, 0);
        check("rs_out", out2, 0);
        check("rs_fifo", pcount0, 0);
        check("rs_last", plast0, 0);
        check("rs_valid", pvalid0, 0);
        @(negedge clk);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        b0 = n_wr0;
        io_write(16'h0805, 8'h96);
        check("rs_wr_cnt", n_wr0 - b0, 1);
        check("rs_wdata", wdata0, 8'h96);
        check("rs_addr", addr0, 5'd5);

        $display("%0d/%0d checks passed", passed, passed + failed);
        $finish;
    end

endmodule

`default_nettype wire
